// File: rtl/multi_data_sync.sv
// Multi-channel enable-qualified bus synchronizer: the per-channel enable is
// synchronized, and the data slice is captured once per enable event.
module multi_data_sync #(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           data_ack,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           data_valid,
  output logic [NUM_CH-1:0]           overrun
);

  logic [NUM_CH-1:0][NUM_STAGES-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0]                 prev_en_q;
  logic [NUM_CH-1:0]                 sync_en;
  logic [NUM_CH-1:0]                 event_c;
  logic [NUM_CH-1:0]                 pulse_q, pulse_d;
  logic [NUM_CH-1:0]                 valid_q, valid_d;
  logic [NUM_CH-1:0]                 ovr_q, ovr_d;
  logic [NUM_CH*BUS_WIDTH-1:0]       bus_q, bus_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sync_en[g] = sync_q[g][NUM_STAGES-1];
    // Level mode reacts to rising edges only; toggle mode to either edge.
    if (TOGGLE_MODE != 0) begin : g_tgl
      assign event_c[g] = sync_en[g] ^ prev_en_q[g];
    end else begin : g_lvl
      assign event_c[g] = sync_en[g] & ~prev_en_q[g];
    end
  end

  always_comb begin
    sync_d  = sync_q;
    bus_d   = bus_q;
    pulse_d = '0;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sync_d[c] = {sync_q[c][NUM_STAGES-2:0], bus_enable[c]};
      if (event_c[c]) begin
        bus_d[c*BUS_WIDTH +: BUS_WIDTH] = unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
        pulse_d[c] = 1'b1;
        valid_d[c] = 1'b1;
      end else if (data_ack[c]) begin
        valid_d[c] = 1'b0;
      end
      // An ack always clears overrun, even when a capture would overrun.
      if (data_ack[c]) begin
        ovr_d[c] = 1'b0;
      end else if (event_c[c] && valid_q[c]) begin
        ovr_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= '0;
      prev_en_q <= '0;
      bus_q     <= '0;
      pulse_q   <= '0;
      valid_q   <= '0;
      ovr_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_en_q <= sync_en;
      bus_q     <= bus_d;
      pulse_q   <= pulse_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sync_bus     = bus_q;
  assign enable_pulse = pulse_q;
  assign data_valid   = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_multi_data_sync.sv
// Scoreboard bench: a level-mode 4-channel instance and a toggle-mode 1-channel
// instance; each expected capture is queued with its data and pulse cycle.
module tb_multi_data_sync;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] unsync_l;
  logic [3:0]  en_l, ack_l;
  logic [31:0] sync_l;
  logic [3:0]  pulse_l, valid_l, ovr_l;
  logic [7:0]  unsync_t;
  logic        en_t, ack_t;
  logic [7:0]  sync_t;
  logic        pulse_t, valid_t, ovr_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q_l [4][$];
  exp_t q_t [$];

  multi_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .NUM_CH(4), .TOGGLE_MODE(0)) u_lvl (
    .CLK(clk), .RST(rst), .unsync_bus(unsync_l), .bus_enable(en_l), .data_ack(ack_l),
    .sync_bus(sync_l), .enable_pulse(pulse_l), .data_valid(valid_l), .overrun(ovr_l)
  );

  multi_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .NUM_CH(1), .TOGGLE_MODE(1)) u_tgl (
    .CLK(clk), .RST(rst), .unsync_bus(unsync_t), .bus_enable(en_t), .data_ack(ack_t),
    .sync_bus(sync_t), .enable_pulse(pulse_t), .data_valid(valid_t), .overrun(ovr_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Enable sampled at the next edge, pulse visible after two further edges.
  task automatic push_l(input int c, input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 3;
    q_l[c].push_back(e);
  endtask

  task automatic push_t(input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 3;
    q_t.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (pulse_l[c] === 1'b1) begin
        checks++;
        if (q_l[c].size() == 0) begin
          failures++;
          $display("FAIL lvl_unexpected_pulse ch%0d actual=pulse at cyc %0d expected=no pulse", c, cyc);
        end else begin
          exp_t e;
          e = q_l[c].pop_front();
          if (sync_l[c*8 +: 8] !== e.data || cyc != e.cyc || valid_l[c] !== 1'b1) begin
            failures++;
            $display("FAIL lvl_capture ch%0d actual=data %h cyc %0d valid %b expected=data %h cyc %0d valid 1",
                     c, sync_l[c*8 +: 8], cyc, valid_l[c], e.data, e.cyc);
          end
        end
      end
    end
    if (pulse_t === 1'b1) begin
      checks++;
      if (q_t.size() == 0) begin
        failures++;
        $display("FAIL tgl_unexpected_pulse actual=pulse at cyc %0d expected=no pulse", cyc);
      end else begin
        exp_t e;
        e = q_t.pop_front();
        if (sync_t !== e.data || cyc != e.cyc || valid_t !== 1'b1) begin
          failures++;
          $display("FAIL tgl_capture actual=data %h cyc %0d valid %b expected=data %h cyc %0d valid 1",
                   sync_t, cyc, valid_t, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; unsync_l = '0; en_l = '0; ack_l = '0;
    unsync_t = '0; en_t = 1'b0; ack_t = 1'b0;
    tick(3);
    chk("rst_sync_l", sync_l, 32'h0);
    chk("rst_flags_l", {20'h0, pulse_l, valid_l, ovr_l}, 32'h0);
    chk("rst_t", {21'h0, sync_t, pulse_t, valid_t, ovr_t}, 32'h0);
    rst = 1'b0;
    tick(2);
    chk("idle_flags_l", {20'h0, pulse_l, valid_l, ovr_l}, 32'h0);

    // Basic level capture on ch0
    unsync_l[7:0] = 8'hA5; en_l[0] = 1'b1; push_l(0, 8'hA5);
    tick(6);
    chk("a5_data", {24'h0, sync_l[7:0]}, 32'hA5);
    chk("a5_valid", {31'h0, valid_l[0]}, 32'h1);
    chk("a5_ovr", {31'h0, ovr_l[0]}, 32'h0);
    en_l[0] = 1'b0; ack_l[0] = 1'b1; tick(1); ack_l[0] = 1'b0;
    chk("a5_ack_valid", {31'h0, valid_l[0]}, 32'h0);

    // Ack while not valid changes nothing
    tick(4);
    ack_l[0] = 1'b1; tick(1); ack_l[0] = 1'b0;
    chk("noop_ack_data", {24'h0, sync_l[7:0]}, 32'hA5);
    chk("noop_ack_flags", {30'h0, valid_l[0], ovr_l[0]}, 32'h0);

    // Level held for 50 cycles yields one pulse
    unsync_l[7:0] = 8'h5A; en_l[0] = 1'b1; push_l(0, 8'h5A);
    tick(50);
    chk("hold_data", {24'h0, sync_l[7:0]}, 32'h5A);
    chk("hold_valid", {31'h0, valid_l[0]}, 32'h1);
    en_l[0] = 1'b0; ack_l[0] = 1'b1; tick(1); ack_l[0] = 1'b0;
    tick(4);

    // Overrun on ch1: newest data wins
    unsync_l[15:8] = 8'h10; en_l[1] = 1'b1; push_l(1, 8'h10);
    tick(5); en_l[1] = 1'b0; tick(4);
    unsync_l[15:8] = 8'h20; en_l[1] = 1'b1; push_l(1, 8'h20);
    tick(5);
    chk("ovr_data", {24'h0, sync_l[15:8]}, 32'h20);
    chk("ovr_flags", {30'h0, valid_l[1], ovr_l[1]}, 32'h3);
    en_l[1] = 1'b0; ack_l[1] = 1'b1; tick(1); ack_l[1] = 1'b0;
    chk("ovr_ack_flags", {30'h0, valid_l[1], ovr_l[1]}, 32'h0);

    // Capture coincident with ack on ch2
    unsync_l[23:16] = 8'h30; en_l[2] = 1'b1; push_l(2, 8'h30);
    tick(5); en_l[2] = 1'b0; tick(4);
    chk("coin_pre_valid", {31'h0, valid_l[2]}, 32'h1);
    unsync_l[23:16] = 8'h40; en_l[2] = 1'b1; push_l(2, 8'h40);
    tick(2); ack_l[2] = 1'b1; tick(1); ack_l[2] = 1'b0;
    chk("coin_data", {24'h0, sync_l[23:16]}, 32'h40);
    chk("coin_flags", {30'h0, valid_l[2], ovr_l[2]}, 32'h2);
    en_l[2] = 1'b0; ack_l = 4'hF; tick(1); ack_l = '0;
    tick(4);

    // All four channels at once
    unsync_l = 32'h04030201; en_l = 4'hF;
    for (int c = 0; c < 4; c++) push_l(c, 8'(c + 1));
    tick(6);
    chk("multi_data", sync_l, 32'h04030201);
    chk("multi_flags", {24'h0, valid_l, ovr_l}, 32'hF0);
    en_l = '0; ack_l = 4'hF; tick(1); ack_l = '0;
    chk("multi_ack_valid", {28'h0, valid_l}, 32'h0);
    tick(4);

    // Reset one cycle after enable rises, enable held through release
    unsync_l = 32'h77000000; en_l[3] = 1'b1;
    tick(1); rst = 1'b1; tick(2);
    chk("midrst_sync", sync_l, 32'h0);
    chk("midrst_flags", {20'h0, pulse_l, valid_l, ovr_l}, 32'h0);
    rst = 1'b0; push_l(3, 8'h77);
    tick(6);
    chk("rel_data", {24'h0, sync_l[31:24]}, 32'h77);
    chk("rel_valid", {28'h0, valid_l}, 32'h8);
    en_l[3] = 1'b0; ack_l[3] = 1'b1; tick(1); ack_l[3] = 1'b0;

    // Toggle mode: three toggles, no ack
    unsync_t = 8'h11; en_t = ~en_t; push_t(8'h11); tick(5);
    unsync_t = 8'h22; en_t = ~en_t; push_t(8'h22); tick(5);
    unsync_t = 8'h33; en_t = ~en_t; push_t(8'h33); tick(5);
    chk("tgl_data", {24'h0, sync_t}, 32'h33);
    chk("tgl_flags", {30'h0, valid_t, ovr_t}, 32'h3);
    ack_t = 1'b1; tick(1); ack_t = 1'b0;
    chk("tgl_ack_flags", {30'h0, valid_t, ovr_t}, 32'h0);

    tick(5);
    for (int c = 0; c < 4; c++) chk($sformatf("lvl_missing_pulse_ch%0d", c), q_l[c].size(), 32'h0);
    chk("tgl_missing_pulse", q_t.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_data_sync.md
MULTI_DATA_SYNC -- requirements
Module: multi_data_sync

Interface
REQ-001 The module SHALL have parameter BUS_WIDTH, default 8, data bits per channel.
REQ-002 The module SHALL have parameter NUM_STAGES, default 2, synchronizer flops per enable; legal range 2..8.
REQ-003 The module SHALL have parameter NUM_CH, default 2, independent channels; legal range 1..16.
REQ-004 The module SHALL have parameter TOGGLE_MODE, default 0: 0 = level enable (rising edge is the event), 1 = toggle enable (any edge is the event).
REQ-005 The module SHALL have port CLK, input, 1, the single destination clock; all flops rise on CLK.
REQ-006 The module SHALL have port RST, input, 1, synchronous active-high reset.
REQ-007 The module SHALL have port unsync_bus, input, NUM_CH*BUS_WIDTH, source data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
REQ-008 The module SHALL have port bus_enable, input, NUM_CH, asynchronous per-channel enable/toggle qualifiers.
REQ-009 The module SHALL have port data_ack, input, NUM_CH, per-channel consumer acknowledge, synchronous to CLK.
REQ-010 The module SHALL have port sync_bus, output, NUM_CH*BUS_WIDTH, captured data, same slicing as unsync_bus.
REQ-011 The module SHALL have port enable_pulse, output, NUM_CH, one-cycle strobe per capture.
REQ-012 The module SHALL have port data_valid, output, NUM_CH, sticky "unconsumed data present" flag.
REQ-013 The module SHALL have port overrun, output, NUM_CH, sticky "capture overwrote unconsumed data" flag.

Function
REQ-014 Each channel SHALL pass bus_enable[c] through a NUM_STAGES-deep flop chain; sync_en[c] is the last stage.
REQ-015 Each channel SHALL register sync_en[c] into prev_en[c]; event[c] = sync_en & ~prev_en (TOGGLE_MODE=0) or sync_en ^ prev_en (TOGGLE_MODE=1).
REQ-016 unsync_bus SHALL NOT be synchronized bit-wise; it is sampled only when event[c]=1, and the source must hold it stable from the enable assertion/toggle until enable_pulse.
REQ-017 On event[c], the next CLK edge SHALL load the channel slice of unsync_bus into sync_bus and drive enable_pulse[c]=1 for exactly one cycle; otherwise sync_bus holds and enable_pulse=0.
REQ-018 Latency: a bus_enable change first sampled at edge k SHALL produce enable_pulse[c]=1 in the cycle after edge k+NUM_STAGES.
REQ-019 Level mode: holding bus_enable high SHALL produce one pulse only; a new pulse requires a low phase of at least NUM_STAGES+1 cycles.
REQ-020 Toggle mode: each transition SHALL produce one pulse; transitions must be spaced at least NUM_STAGES+1 cycles apart.
REQ-021 data_valid[c] SHALL set on the edge that captures and clear on an edge where data_ack[c]=1 and no capture occurs.
REQ-022 data_ack[c] while data_valid[c]=0 SHALL be ignored.
REQ-023 Capture and data_ack in the same cycle: the new data SHALL load, data_valid stays 1, and overrun SHALL NOT set.
REQ-024 Capture while data_valid=1 and data_ack=0: the data SHALL be overwritten (newest wins) and overrun[c] set.
REQ-025 overrun[c] SHALL stay set until an edge with data_ack[c]=1, which clears it; if an overrun condition coincides with that ack, it still clears.
REQ-026 Channels SHALL be fully independent; there is no cross-channel arbitration or ordering.

Reset
REQ-027 While RST=1 at an edge, all synchronizer flops, prev_en, sync_bus, enable_pulse, data_valid and overrun SHALL become 0.
REQ-028 Assertion mid-operation SHALL discard in-flight events; no pulse is generated for an enable change sampled before the reset edge.
REQ-029 If bus_enable[c]=1 at reset release (either mode), one event SHALL be generated, with enable_pulse at the cycle after edge NUM_STAGES+1 following release.

Verification
REQ-030 NUM_STAGES=2, level mode, ch0: bus_enable 0->1 with unsync_bus=0xA5 sampled at edge k -> enable_pulse[0]=1 after edge k+2 only, sync_bus[7:0]=0xA5, data_valid[0]=1.
REQ-031 Toggle mode: three toggles spaced 5 cycles with data 0x11, 0x22, 0x33 and no ack -> three pulses, final sync_bus=0x33, overrun=1, data_valid=1; data_ack -> both 0.
REQ-032 Capture coincident with data_ack while data_valid=1 -> new data, data_valid=1, overrun=0.
REQ-033 NUM_CH=4: simultaneous enables with distinct data 0x01..0x04 -> four pulses in the same cycle, correct slices, no crosstalk.
REQ-034 RST=1 one cycle after bus_enable rises -> no pulse and all outputs 0; if bus_enable is held high after release -> one pulse NUM_STAGES+1 cycles later.
REQ-035 data_ack with data_valid=0 -> no state change; level enable held high for 50 cycles -> exactly one pulse.
